// File: rtl/pwm_servo_decoder.sv
// Servo PWM receiver: measures the high time of an incoming servo pulse and converts
// it back to the 0..MAX_ANGLE code, flagging malformed pulses and loss of signal.
module pwm_servo_decoder #(
  parameter int OFFSET_CLKS    = 30000,
  parameter int STEP_CLKS      = 500,
  parameter int MAX_ANGLE      = 180,
  parameter int MIN_PULSE_CLKS = 25000,
  parameter int MAX_PULSE_CLKS = 150000,
  parameter int LOST_CLKS      = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       pulse_err,
  output logic       signal_lost
);

  localparam int WIDTH_W = 18;
  localparam int LOST_W  = 21;

  localparam logic [WIDTH_W-1:0] FIRST_THR =
    WIDTH_W'(OFFSET_CLKS - STEP_CLKS / 2 + STEP_CLKS);
  localparam logic [WIDTH_W-1:0] STEP_W    = WIDTH_W'(STEP_CLKS);
  localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_PULSE_CLKS);
  localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_PULSE_CLKS);
  localparam logic [LOST_W-1:0]  LOST_L    = LOST_W'(LOST_CLKS);
  localparam logic [7:0]         ANGLE_MAX = 8'(MAX_ANGLE);

  typedef enum logic [1:0] {ARM, LOW, HIGH} state_t;

  function automatic logic [7:0] sat_angle_inc(input logic [7:0] a);
    return (a >= ANGLE_MAX) ? ANGLE_MAX : a + 8'd1;
  endfunction

  function automatic logic [LOST_W-1:0] sat_lost_inc(input logic [LOST_W-1:0] c);
    return (c >= LOST_L) ? LOST_L : c + LOST_W'(1);
  endfunction

  logic               pwm_p0, pwm_p1, pwm_p2;
  logic               rise, fall;
  state_t             state, state_nxt;
  logic [WIDTH_W-1:0] width, width_inc, thr;
  logic [7:0]         acc;
  logic               start, count, decode_ok, reject;
  logic [LOST_W-1:0]  lost_cnt, lost_nxt;

  // Stage p0/p1: two-flop synchronizer; stage p2: history flop for edge detection
  always_ff @(posedge clk) begin
    pwm_p0 <= pwm_in;
    pwm_p1 <= pwm_p0;
    pwm_p2 <= pwm_p1;
  end

  assign rise      = pwm_p1 & ~pwm_p2;
  assign fall      = ~pwm_p1 & pwm_p2;
  assign width_inc = width + WIDTH_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    count     = 1'b0;
    decode_ok = 1'b0;
    reject    = 1'b0;
    case (state)
      ARM: begin
        if (!pwm_p1) state_nxt = LOW;
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
          start     = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
          if (width < MIN_W) reject    = 1'b1;
          else               decode_ok = 1'b1;
        end else if (width_inc == MAX_W) begin
          // Over-long pulse: rearm only after the line has gone low again
          state_nxt = ARM;
          reject    = 1'b1;
          count     = 1'b1;
        end else begin
          count = 1'b1;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

  // The rise cycle already holds one high sample, hence width starts at 1.
  // acc counts rounding thresholds crossed, giving round-to-nearest without a divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width <= '0;
      acc   <= '0;
      thr   <= FIRST_THR;
    end else if (start) begin
      width <= WIDTH_W'(1);
      acc   <= '0;
      thr   <= FIRST_THR;
    end else if (count) begin
      width <= width_inc;
      if (width_inc == thr) begin
        acc <= sat_angle_inc(acc);
        thr <= thr + STEP_W;
      end
    end else if (state != HIGH) begin
      width <= '0;
      acc   <= '0;
      thr   <= FIRST_THR;
    end
  end

  assign lost_nxt = rise ? '0 : sat_lost_inc(lost_cnt);

  // Output stage: strobes, held angle and loss-of-signal level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle       <= '0;
      angle_valid <= 1'b0;
      pulse_err   <= 1'b0;
      signal_lost <= 1'b1;
      lost_cnt    <= '0;
    end else begin
      angle_valid <= decode_ok;
      pulse_err   <= reject;
      lost_cnt    <= lost_nxt;
      if (decode_ok) angle <= acc;
      if (decode_ok)
        signal_lost <= 1'b0;
      else if (lost_cnt != LOST_L && lost_nxt == LOST_L)
        signal_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_servo_decoder.sv
// Bench for pwm_servo_decoder with time-scaled parameters: a pulse-level model predicts
// every output cycle by cycle, and directed pulses pin the model to hand-computed values.
module tb_pwm_servo_decoder;

  localparam int OFFSET = 300;
  localparam int STEP   = 10;
  localparam int MAXA   = 180;
  localparam int MINP   = 250;
  localparam int MAXP   = 2500;
  localparam int LOST   = 12500;
  localparam int GAP    = 300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic [7:0] angle;
  logic       angle_valid;
  logic       pulse_err;
  logic       signal_lost;

  pwm_servo_decoder #(
    .OFFSET_CLKS(OFFSET), .STEP_CLKS(STEP), .MAX_ANGLE(MAXA),
    .MIN_PULSE_CLKS(MINP), .MAX_PULSE_CLKS(MAXP), .LOST_CLKS(LOST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .angle(angle),
    .angle_valid(angle_valid), .pulse_err(pulse_err), .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int decode(input int w);
    int t;
    t = w - OFFSET + STEP / 2;
    if (t < 0) return 0;
    t = t / STEP;
    if (t > MAXA) return MAXA;
    return t;
  endfunction

  // Pulse-level model: runs of high samples become decode/reject events two edges
  // after the edge that ends (or overruns) them.
  int exp_angle = 0;
  bit exp_valid = 0, exp_err = 0, exp_lost = 1;
  bit armed = 0, in_run = 0, prev_s = 0, m_s;
  int run_start = 0, m_w;
  bit pend = 0, pend_is_valid = 0;
  int pend_edge = 0, pend_angle = 0;
  int zero_edge = 0, zero_pending = -1;

  always @(posedge clk) begin
    m_s = pwm_in;
    cyc++;
    exp_valid = 0;
    exp_err   = 0;
    if (!rst_n) begin
      armed = 0; in_run = 0; pend = 0;
      exp_angle = 0; exp_lost = 1; zero_edge = cyc;
    end else begin
      if (cyc == zero_pending) zero_edge = cyc;
      if (pend && pend_edge == cyc) begin
        pend = 0;
        if (pend_is_valid) begin
          exp_valid = 1; exp_angle = pend_angle; exp_lost = 0;
        end else begin
          exp_err = 1;
        end
      end
      if (!exp_valid && cyc == zero_edge + LOST) exp_lost = 1;
      if (!armed) begin
        if (!m_s) armed = 1;
      end else if (m_s && !prev_s) begin
        in_run = 1; run_start = cyc;
      end else if (in_run && m_s && (cyc - run_start + 1) == MAXP) begin
        in_run = 0; armed = 0;
        pend = 1; pend_edge = cyc + 2; pend_is_valid = 0;
      end else if (in_run && !m_s) begin
        in_run = 0;
        m_w = cyc - run_start;
        pend = 1; pend_edge = cyc + 2;
        pend_is_valid = (m_w >= MINP);
        pend_angle = decode(m_w);
      end
    end
    if (m_s && !prev_s) zero_pending = cyc + 2;
    prev_s = m_s;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("angle", int'(angle), exp_angle);
      chk("angle_valid", int'(angle_valid), int'(exp_valid));
      chk("pulse_err", int'(pulse_err), int'(exp_err));
      chk("signal_lost", int'(signal_lost), int'(exp_lost));
    end
  end

  task automatic pulse(input int w, input int gap, input int lit_angle,
                       input int lit_valid, input int lit_err, input string nm);
    int nv, ne, first;
    nv = 0; ne = 0; first = -1;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (w) begin
      @(negedge clk);
      nv += int'(angle_valid);
      ne += int'(pulse_err);
    end
    pwm_in = 1'b0;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      nv += int'(angle_valid);
      ne += int'(pulse_err);
      if ((angle_valid || pulse_err) && first < 0) first = i;
    end
    chk({nm, " valid strobes"}, nv, lit_valid);
    chk({nm, " err strobes"}, ne, lit_err);
    chk({nm, " angle"}, int'(angle), lit_angle);
    chk({nm, " model angle"}, exp_angle, lit_angle);
    if (w < MAXP && (lit_valid + lit_err) > 0) chk({nm, " latency"}, first, 3);
  endtask

  initial begin
    int nv, ne, lost_at;
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset angle", int'(angle), 0);
    chk("reset angle_valid", int'(angle_valid), 0);
    chk("reset pulse_err", int'(pulse_err), 0);
    chk("reset signal_lost", int'(signal_lost), 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    pulse(2200, GAP, 180, 1, 0, "w2200 first");
    chk("lost cleared by decode", int'(signal_lost), 0);
    pulse(2200, GAP, 180, 1, 0, "w2200 repeat");
    pulse(300,  GAP, 0,   1, 0, "w300");
    pulse(750,  GAP, 45,  1, 0, "w750");
    pulse(1200, GAP, 90,  1, 0, "w1200");
    pulse(2300, GAP, 180, 1, 0, "w2300 sat");
    pulse(1205, GAP, 91,  1, 0, "w1205 round up");
    pulse(1204, GAP, 90,  1, 0, "w1204 round down");
    pulse(5,    GAP, 90,  0, 1, "w5 short");
    pulse(249,  GAP, 90,  0, 1, "w249 below min");
    pulse(250,  GAP, 0,   1, 0, "w250 at min");
    pulse(2499, GAP, 180, 1, 0, "w2499 below max");
    pulse(3100, GAP, 180, 0, 1, "w3100 overlong");
    pulse(1200, GAP, 90,  1, 0, "w1200 after overlong");

    // Loss of signal: long low after a valid pulse
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (1200) @(negedge clk);
    pwm_in = 1'b0;
    lost_at = -1;
    for (int i = 1; i <= 13000; i++) begin
      @(negedge clk);
      if (signal_lost && lost_at < 0) lost_at = i;
    end
    chk("lost latency", lost_at, LOST - 1200 + 3);
    chk("angle held while lost", int'(angle), 90);
    pulse(1200, GAP, 90, 1, 0, "w1200 after loss");
    chk("lost cleared again", int'(signal_lost), 0);

    // Reset in the middle of a pulse
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset angle", int'(angle), 0);
    chk("midreset angle_valid", int'(angle_valid), 0);
    chk("midreset pulse_err", int'(pulse_err), 0);
    chk("midreset signal_lost", int'(signal_lost), 1);
    rst_n = 1'b1;
    nv = 0; ne = 0;
    repeat (600) begin
      @(negedge clk);
      nv += int'(angle_valid);
      ne += int'(pulse_err);
    end
    pwm_in = 1'b0;
    repeat (GAP) begin
      @(negedge clk);
      nv += int'(angle_valid);
      ne += int'(pulse_err);
    end
    chk("truncated valid strobes", nv, 0);
    chk("truncated err strobes", ne, 0);
    pulse(1200, GAP, 90, 1, 0, "w1200 after reset");
    chk("lost cleared after reset", int'(signal_lost), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
